// File: rtl/mc_bus_master_if.sv
// ---------------------------------------------------------------------------
// mc_bus_master_if
// Bundles the request/response port and the MCU parallel bus of
// mc_bus_master.
//   master modport : the bus master itself (drives req_ready, rsp_*, busy
//                    and the mc_* bus, samples req_* and mc_data_in)
//   slave  modport : the client/bus-device side (drives req_* and
//                    mc_data_in, observes everything else)
// Signals:
//   req_valid/req_ready/req_write/req_addr/req_wdata : request handshake
//   rsp_valid/rsp_rdata                              : read response
//   busy                                             : work pending/active
//   mc_add/mc_data_out/mc_data_oe/mc_data_in         : bus address/data
//   mc_ce/mc_we/mc_oe                                : active-low strobes
// ---------------------------------------------------------------------------
interface mc_bus_master_if #(
  parameter int MC_DATA_WIDTH = 16,
  parameter int MC_ADD_WIDTH  = 6
);
  logic                     req_valid;
  logic                     req_ready;
  logic                     req_write;
  logic [MC_ADD_WIDTH-1:0]  req_addr;
  logic [MC_DATA_WIDTH-1:0] req_wdata;
  logic                     rsp_valid;
  logic [MC_DATA_WIDTH-1:0] rsp_rdata;
  logic                     busy;
  logic [MC_ADD_WIDTH-1:0]  mc_add;
  logic [MC_DATA_WIDTH-1:0] mc_data_out;
  logic                     mc_data_oe;
  logic [MC_DATA_WIDTH-1:0] mc_data_in;
  logic                     mc_ce;
  logic                     mc_we;
  logic                     mc_oe;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata, mc_data_in,
    output req_ready, rsp_valid, rsp_rdata, busy,
           mc_add, mc_data_out, mc_data_oe, mc_ce, mc_we, mc_oe
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata, mc_data_in,
    input  req_ready, rsp_valid, rsp_rdata, busy,
           mc_add, mc_data_out, mc_data_oe, mc_ce, mc_we, mc_oe
  );
endinterface

// File: rtl/mc_bus_master.sv
// ---------------------------------------------------------------------------
// mc_bus_master
// Queued master for the MCU parallel bus. Requests accepted on a valid/ready
// port are buffered in a FIFO and replayed one at a time as a
// SETUP -> STROBE -> HOLD bus cycle with parameterised phase lengths.
// Read data is sampled on the last STROBE cycle and returned with a one-cycle
// rsp_valid pulse on the first HOLD cycle.
// Ports:
//   clock : system clock, rising edge
//   reset : asynchronous, active-low
//   bus   : mc_bus_master_if.master (request, response, busy and mc_* bus)
// ---------------------------------------------------------------------------
module mc_bus_master #(
  parameter int MC_DATA_WIDTH = 16,
  parameter int MC_ADD_WIDTH  = 6,
  parameter int QUEUE_DEPTH   = 8,
  parameter int SETUP_CYCLES  = 3,
  parameter int STROBE_CYCLES = 6,
  parameter int HOLD_CYCLES   = 3
) (
  input logic             clock,
  input logic             reset,
  mc_bus_master_if.master bus
);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_STROBE, S_HOLD} state_t;

  typedef struct packed {
    logic                     write;
    logic [MC_ADD_WIDTH-1:0]  addr;
    logic [MC_DATA_WIDTH-1:0] wdata;
  } req_t;

  localparam int PW   = $clog2(QUEUE_DEPTH);
  localparam int MAXC = (SETUP_CYCLES > STROBE_CYCLES)
                        ? ((SETUP_CYCLES  > HOLD_CYCLES) ? SETUP_CYCLES  : HOLD_CYCLES)
                        : ((STROBE_CYCLES > HOLD_CYCLES) ? STROBE_CYCLES : HOLD_CYCLES);
  localparam int CW   = $clog2(MAXC) + 1;

  localparam logic [CW-1:0] SETUP_LOAD  = CW'(SETUP_CYCLES  - 1);
  localparam logic [CW-1:0] STROBE_LOAD = CW'(STROBE_CYCLES - 1);
  localparam logic [CW-1:0] HOLD_LOAD   = CW'(HOLD_CYCLES   - 1);

  // ---------------- request FIFO ----------------
  req_t        r_mem [QUEUE_DEPTH];
  logic [PW:0] r_wr_ptr;
  logic [PW:0] r_rd_ptr;
  logic        w_empty;
  logic        w_full;
  logic        w_push;
  logic        w_pop;
  req_t        w_head;

  // Extra wrap bit distinguishes full from empty when the index bits match.
  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[PW] != r_rd_ptr[PW]) &&
                   (r_wr_ptr[PW-1:0] == r_rd_ptr[PW-1:0]);
  // A full FIFO refuses a push even when a pop happens in the same cycle.
  assign w_push  = bus.req_valid && !w_full;
  assign w_head  = r_mem[r_rd_ptr[PW-1:0]];

  // NOTE: storage has no reset; only the pointers define what is valid.
  always_ff @(posedge clock) begin
    if (w_push) begin
      r_mem[r_wr_ptr[PW-1:0]] <= {bus.req_write, bus.req_addr, bus.req_wdata};
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // sees the pre-edge value of every other register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // ---------------- bus sequencer ----------------
  state_t        r_state;
  state_t        w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  req_t          r_cur;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_cur   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_pop) r_cur <= w_head;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_pop       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_state_nxt = S_SETUP;
          w_cnt_nxt   = SETUP_LOAD;
        end
      end
      S_SETUP: begin
        if (r_cnt == '0) begin
          w_state_nxt = S_STROBE;
          w_cnt_nxt   = STROBE_LOAD;
        end else begin
          w_cnt_nxt = r_cnt - CW'(1);
        end
      end
      S_STROBE: begin
        if (r_cnt == '0) begin
          w_state_nxt = S_HOLD;
          w_cnt_nxt   = HOLD_LOAD;
        end else begin
          w_cnt_nxt = r_cnt - CW'(1);
        end
      end
      S_HOLD: begin
        if (r_cnt != '0) begin
          w_cnt_nxt = r_cnt - CW'(1);
        end else if (!w_empty) begin
          // Pop on the last HOLD cycle so the next SETUP follows with no gap.
          w_pop       = 1'b1;
          w_state_nxt = S_SETUP;
          w_cnt_nxt   = SETUP_LOAD;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Bus controls decode straight from the registered state, so an async
  // reset releases the strobes immediately.
  logic w_ce;
  logic w_we;
  logic w_oe;
  logic w_data_oe;

  always_comb begin
    w_ce      = 1'b1;
    w_we      = 1'b1;
    w_oe      = 1'b1;
    w_data_oe = 1'b0;
    case (r_state)
      S_SETUP: begin
        w_ce      = 1'b0;
        w_data_oe = r_cur.write;
      end
      S_STROBE: begin
        w_ce = 1'b0;
        if (r_cur.write) begin
          w_we      = 1'b0;
          w_data_oe = 1'b1;
        end else begin
          w_oe = 1'b0;
        end
      end
      S_HOLD: begin
        w_ce      = 1'b0;
        w_data_oe = r_cur.write;
      end
      default: ;
    endcase
  end

  // ---------------- read response ----------------
  logic                     r_rsp_valid;
  logic [MC_DATA_WIDTH-1:0] r_rsp_rdata;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
    end else begin
      r_rsp_valid <= 1'b0;
      if (r_state == S_STROBE && r_cnt == '0 && !r_cur.write) begin
        r_rsp_valid <= 1'b1;
        r_rsp_rdata <= bus.mc_data_in;
      end
    end
  end

  assign bus.req_ready   = !w_full;
  assign bus.busy        = (r_state != S_IDLE) || !w_empty;
  assign bus.mc_add      = r_cur.addr;
  assign bus.mc_data_out = r_cur.wdata;
  assign bus.mc_data_oe  = w_data_oe;
  assign bus.mc_ce       = w_ce;
  assign bus.mc_we       = w_we;
  assign bus.mc_oe       = w_oe;
  assign bus.rsp_valid   = r_rsp_valid;
  assign bus.rsp_rdata   = r_rsp_rdata;

endmodule
